// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state enum, the [row][col] key-map table and the
// row-priority and column-drive helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_t;

    // Hex code for each key, indexed [row][col]; '*' maps to E and '#' to F
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Lowest-index row that reads low (down); only meaningful when rs != 4'hF
    function automatic logic [1:0] lowest_down(input logic [3:0] rs);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // One-cold column drive for column index c
    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad-side and consumer-side signals of the scanner.
// slave is the scanner's view, master is the environment's view.
interface keypad_scanner_if;
    logic       tick;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        output tick, rows,
        input  cols, key, key_valid, key_held
    );

    modport slave (
        input  tick, rows,
        output cols, key, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// sync2: parameterized-width two-flop synchronizer with async reset.
module sync2 #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Two back-to-back flops to resolve metastability on asynchronous inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad on each divider tick,
// debounces press and release over DEBOUNCE_TICKS samples, and emits a
// registered hex key code with a one-cycle key_valid pulse per press.
// Define KEYPAD_SYNC_EN to pass rows through a 2-flop synchronizer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.slave   bus
);
    localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

    logic [3:0] rs;
    kp_state_t  state;
    logic [1:0] c;
    logic [1:0] r_lat;
    logic [3:0] cnt;
    logic [3:0] cols_q;
    logic [3:0] key_q;
    logic       valid_q;
    logic       held_q;

    logic [1:0] c_next;
    logic [1:0] low_row;
    logic [3:0] cnt_inc;
    logic       any_down;
    logic       lat_down;

`ifdef KEYPAD_SYNC_EN
    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rows),
        .q     (rs)
    );
`else
    assign rs = bus.rows;
`endif

    assign c_next   = c + 2'd1;
    assign low_row  = lowest_down(rs);
    assign any_down = (rs != 4'hF);
    assign lat_down = ~rs[r_lat];
    assign cnt_inc  = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    // Scan/debounce FSM; all state moves on tick, key_valid self-clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            c       <= '0;
            cols_q  <= 4'b1110;
            r_lat   <= '0;
            cnt     <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.tick) begin
                unique case (state)
                    SCAN: begin
                        if (any_down) begin
                            r_lat <= low_row;
                            cnt   <= 4'd1;
                            if (DT <= 4'd1) begin
                                key_q   <= KEY_MAP[low_row][c];
                                valid_q <= 1'b1;
                                held_q  <= 1'b1;
                                state   <= HELD;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            c      <= c_next;
                            cols_q <= col_drive(c_next);
                        end
                    end
                    DEBOUNCE: begin
                        if (lat_down) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DT) begin
                                key_q   <= KEY_MAP[r_lat][c];
                                valid_q <= 1'b1;
                                held_q  <= 1'b1;
                                state   <= HELD;
                            end
                        end else begin
                            cnt    <= '0;
                            c      <= c_next;
                            cols_q <= col_drive(c_next);
                            state  <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!lat_down) begin
                            if (DT <= 4'd1) begin
                                cnt    <= '0;
                                held_q <= 1'b0;
                                c      <= c_next;
                                cols_q <= col_drive(c_next);
                                state  <= SCAN;
                            end else begin
                                cnt   <= 4'd1;
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (!lat_down) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DT) begin
                                cnt    <= '0;
                                held_q <= 1'b0;
                                c      <= c_next;
                                cols_q <= col_drive(c_next);
                                state  <= SCAN;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign bus.cols      = cols_q;
    assign bus.key       = key_q;
    assign bus.key_valid = valid_q;
    assign bus.key_held  = held_q;

endmodule
